// File: rtl/muldiv_sequencer.sv
// Sequential signed multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on 33-bit magnitudes, with HI/LO result write pulses.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        multStart,
    input  logic        divStart,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        hiWrite,
    output logic        loWrite,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, DONE, DZERO} state_t;

    state_t      state;
    state_t      nextState;
    logic [5:0]  count;
    logic        signA;
    logic        signB;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [32:0] bReg;
    logic [31:0] rem;
    logic [31:0] quot;

    logic [32:0] opAMag;
    logic [32:0] opBMag;
    logic [32:0] remShift;
    logic [31:0] remDiff;
    logic        qBit;
    logic [31:0] remNext;
    logic [63:0] prodFinal;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;
    logic        lastStep;

    // Sign-extending to 33 bits first lets |0x80000000| become 2^31 cleanly.
    always_comb begin
        opAMag = opA[31] ? (33'd0 - {opA[31], opA}) : {1'b0, opA};
        opBMag = opB[31] ? (33'd0 - {opB[31], opB}) : {1'b0, opB};
    end

    always_comb begin
        remShift  = {rem, quot[31]};
        qBit      = (remShift >= bReg);
        remDiff   = remShift[31:0] - bReg[31:0];
        remNext   = qBit ? remDiff : remShift[31:0];
        prodFinal = (signA ^ signB) ? (64'd0 - acc) : acc;
        quotFinal = (signA ^ signB) ? (32'd0 - quot) : quot;
        remFinal  = signA ? (32'd0 - rem) : rem;
        lastStep  = (count == 6'd32);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (multStart)     nextState = MULT;
                else if (divStart) nextState = (opB == 32'd0) ? DZERO : DIV;
            end
            MULT:    if (lastStep) nextState = DONE;
            DIV:     if (lastStep) nextState = DONE;
            DONE:    nextState = IDLE;
            DZERO:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        div0    = (state == DZERO);
        hiWrite = done;
        loWrite = done;
    end

    // Count runs 0..31 over the iterations; the extra value 32 is the
    // sign-fixup step that writes hi/lo while entering DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 6'd0;
            signA <= 1'b0;
            signB <= 1'b0;
            acc   <= 64'd0;
            mcand <= 64'd0;
            bReg  <= 33'd0;
            rem   <= 32'd0;
            quot  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (multStart || divStart) begin
                        count <= 6'd0;
                        signA <= opA[31];
                        signB <= opB[31];
                        acc   <= 64'd0;
                        mcand <= {31'd0, opAMag};
                        bReg  <= opBMag;
                        rem   <= 32'd0;
                        quot  <= opAMag[31:0];
                    end
                end
                MULT: begin
                    if (lastStep) begin
                        hi <= prodFinal[63:32];
                        lo <= prodFinal[31:0];
                    end else begin
                        if (bReg[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        bReg  <= bReg >> 1;
                        count <= count + 6'd1;
                    end
                end
                DIV: begin
                    if (lastStep) begin
                        hi <= remFinal;
                        lo <= quotFinal;
                    end else begin
                        rem   <= remNext;
                        quot  <= {quot[30:0], qBit};
                        count <= count + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized operations checked against plain 64-bit signed arithmetic.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        multStart = 1'b0;
    logic        divStart = 1'b0;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic        busy, done, div0, hiWrite, loWrite;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .multStart(multStart), .divStart(divStart),
        .opA(opA), .opB(opB), .busy(busy), .done(done), .div0(div0),
        .hiWrite(hiWrite), .loWrite(loWrite), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] modelMult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Returns {remainder, quotient}; 64-bit math makes 0x80000000/-1 wrap naturally.
    function automatic logic [63:0] modelDiv(input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one operation from IDLE and follows it to completion.
    task automatic doOp(input bit isDiv, input bit both, input logic [31:0] a,
                        input logic [31:0] b, input int pulseAt,
                        output int lat, output int busyCnt, output int proto,
                        output bit timedOut, output logic [31:0] h,
                        output logic [31:0] l, output logic afterBusy);
        bit found;
        found = 0; lat = -1; busyCnt = 0; proto = 0; h = 'x; l = 'x;
        opA = a; opB = b;
        multStart = !isDiv || both;
        divStart  = isDiv || both;
        @(posedge clk);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (i == 0) begin multStart = 0; divStart = 0; end
            if (i == pulseAt) multStart = 1;
            else if (pulseAt >= 0 && i == pulseAt + 1) multStart = 0;
            if (done) begin
                found = 1; lat = i; h = hi; l = lo;
                if (!(hiWrite && loWrite && !div0)) proto++;
            end else begin
                if (busy) busyCnt++;
                if (hiWrite || loWrite || div0) proto++;
            end
        end
        multStart = 0;
        timedOut = !found;
        @(negedge clk);
        afterBusy = busy;
        if (done) proto++;
    endtask

    task automatic applyStimulus(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                                 input string name);
        int lat, bc, proto; bit to; logic [31:0] h, l; logic ab;
        logic [63:0] exp;
        exp = isDiv ? modelDiv(a, b) : modelMult(a, b);
        doOp(isDiv, 0, a, b, -1, lat, bc, proto, to, h, l, ab);
        total++; if (to) begin bad++; $display("FAIL %s timeout: done never seen", name); end
        total++; if (lat !== 33) begin bad++; $display("FAIL %s latency: got %0d want 33", name, lat); end
        total++; if (h !== exp[63:32]) begin bad++; $display("FAIL %s hi: got %h want %h", name, h, exp[63:32]); end
        total++; if (l !== exp[31:0]) begin bad++; $display("FAIL %s lo: got %h want %h", name, l, exp[31:0]); end
        total++; if (proto !== 0) begin bad++; $display("FAIL %s pulses: got %0d bad cycles want 0", name, proto); end
    endtask

    task automatic test_reset;
        #1 reset = 0;
        #2;
        total++; if ({busy, done, div0, hiWrite, loWrite} !== 5'b0) begin bad++; $display("FAIL reset flags: got %b want 00000", {busy, done, div0, hiWrite, loWrite}); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset hilo: got %h want 0", {hi, lo}); end
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_mult_basic;
        int lat, bc, proto; bit to; logic [31:0] h, l; logic ab;
        doOp(0, 0, 32'd7, 32'hFFFFFFFD, -1, lat, bc, proto, to, h, l, ab);
        total++; if (lat !== 33) begin bad++; $display("FAIL mult latency: got %0d want 33 (timeout=%0d)", lat, to); end
        total++; if (bc !== 33) begin bad++; $display("FAIL mult busy cycles: got %0d want 33", bc); end
        total++; if (h !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult hi: got %h want ffffffff", h); end
        total++; if (l !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult lo: got %h want ffffffeb", l); end
        total++; if (ab !== 1'b0) begin bad++; $display("FAIL mult busy after done: got %b want 0", ab); end
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL mult hold: got %h want ffffffffffffffeb", {hi, lo}); end
        total++; if (proto !== 0) begin bad++; $display("FAIL mult pulses: got %0d want 0", proto); end
    endtask

    task automatic test_div_basic;
        int lat, bc, proto; bit to; logic [31:0] h, l; logic ab;
        doOp(1, 0, 32'hFFFFFFF9, 32'd2, -1, lat, bc, proto, to, h, l, ab);
        total++; if (lat !== 33) begin bad++; $display("FAIL div latency: got %0d want 33 (timeout=%0d)", lat, to); end
        total++; if (l !== 32'hFFFFFFFD) begin bad++; $display("FAIL div lo: got %h want fffffffd", l); end
        total++; if (h !== 32'hFFFFFFFF) begin bad++; $display("FAIL div hi: got %h want ffffffff", h); end
        total++; if (proto !== 0) begin bad++; $display("FAIL div write pulses: got %0d want 0", proto); end
    endtask

    task automatic test_div_zero;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        opA = 32'd5; opB = 32'd0; divStart = 1;
        @(posedge clk);
        @(negedge clk);
        divStart = 0;
        total++; if ({div0, busy, done, hiWrite, loWrite} !== 5'b11000) begin bad++; $display("FAIL div0 pulse: got %b want 11000", {div0, busy, done, hiWrite, loWrite}); end
        @(negedge clk);
        total++; if ({div0, busy, done} !== 3'b000) begin bad++; $display("FAIL div0 end: got %b want 000", {div0, busy, done}); end
        total++; if ({hi, lo} !== {h0, l0}) begin bad++; $display("FAIL div0 hilo: got %h want %h", {hi, lo}, {h0, l0}); end
    endtask

    task automatic test_corners;
        applyStimulus(1, 32'h80000000, 32'hFFFFFFFF, "div_wrap");
        applyStimulus(0, 32'h80000000, 32'h80000000, "mult_min");
        applyStimulus(1, 32'h80000000, 32'h00000001, "div_min_by_1");
        applyStimulus(1, 32'd7, 32'hFFFFFFF9, "div_neg_divisor");
    endtask

    task automatic test_ignore_start;
        int lat, bc, proto; bit to; logic [31:0] h, l; logic ab;
        doOp(1, 0, 32'd100, 32'd7, 10, lat, bc, proto, to, h, l, ab);
        total++; if (lat !== 33) begin bad++; $display("FAIL ignore latency: got %0d want 33 (timeout=%0d)", lat, to); end
        total++; if ({h, l} !== {32'd2, 32'd14}) begin bad++; $display("FAIL ignore result: got %h want %h", {h, l}, {32'd2, 32'd14}); end
        doOp(1, 1, 32'd6, 32'd3, -1, lat, bc, proto, to, h, l, ab);
        total++; if ({h, l} !== 64'd18) begin bad++; $display("FAIL both starts: got %h want %h", {h, l}, 64'd18); end
        total++; if (lat !== 33) begin bad++; $display("FAIL both latency: got %0d want 33", lat); end
    endtask

    task automatic test_reset_abort;
        int lat, bc, proto; bit to; logic [31:0] h, l; logic ab;
        int sawPulse;
        sawPulse = 0;
        opA = 32'h12345678; opB = 32'h00009ABC; multStart = 1;
        @(posedge clk);
        @(negedge clk);
        multStart = 0;
        repeat (20) @(negedge clk);
        #2 reset = 0;
        #1;
        total++; if ({busy, done, div0, hiWrite, loWrite} !== 5'b0) begin bad++; $display("FAIL abort flags: got %b want 00000", {busy, done, div0, hiWrite, loWrite}); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL abort hilo: got %h want 0", {hi, lo}); end
        repeat (3) begin
            @(negedge clk);
            if (busy || done || hiWrite || loWrite) sawPulse++;
        end
        total++; if (sawPulse !== 0) begin bad++; $display("FAIL abort held: got %0d active cycles want 0", sawPulse); end
        reset = 1;
        doOp(0, 0, 32'd3, 32'd4, -1, lat, bc, proto, to, h, l, ab);
        total++; if (lat !== 33) begin bad++; $display("FAIL post-reset latency: got %0d want 33 (timeout=%0d)", lat, to); end
        total++; if ({h, l} !== 64'd12) begin bad++; $display("FAIL post-reset mult: got %h want %h", {h, l}, 64'd12); end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        bit isDiv;
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: b = $urandom_range(1, 20);
                2: b = -($urandom_range(1, 20));
                default: ;
            endcase
            isDiv = $urandom_range(0, 1);
            if (isDiv && b == 32'd0) b = 32'd1;
            applyStimulus(isDiv, a, b, isDiv ? "rand_div" : "rand_mult");
        end
    endtask

    task automatic checkOutput;
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        $display("[TB] muldiv_sequencer bench start");
        test_reset;
        test_mult_basic;
        test_div_basic;
        test_div_zero;
        test_corners;
        test_ignore_start;
        test_reset_abort;
        test_random;
        checkOutput;
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The port list SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous active-low reset
- multStart  in  1  request signed MULT of opA*opB
- divStart  in  1  request signed DIV of opA/opB
- opA  in  32  multiplicand / dividend, sampled on accepting edge
- opB  in  32  multiplier / divisor, sampled on accepting edge
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; hi/lo valid
- div0  out  1  one-cycle pulse; divide by zero rejected
- hiWrite  out  1  HI register write enable, equals done
- loWrite  out  1  LO register write enable, equals done
- hi  out  32  MULT: product[63:32]; DIV: remainder
- lo  out  32  MULT: product[31:0]; DIV: quotient

Function
REQ-003 The block SHALL implement states IDLE, MULT, DIV, DONE and DZERO.
REQ-004 In IDLE, a start SHALL be accepted on the rising edge where it is high; opA and opB SHALL be latched on that edge.
REQ-005 If multStart and divStart are high together, MULT SHALL win and divStart SHALL be ignored.
REQ-006 A start seen in any state other than IDLE SHALL be ignored with no effect on the running operation.
REQ-007 When divStart is accepted with opB==0, the block SHALL go to DZERO; in DZERO, div0=1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-008 A DZERO pass SHALL leave hi, lo, hiWrite and loWrite unchanged/low.
REQ-009 MULT and DIV SHALL each run a 6-bit iteration counter from 0 to 31, one iteration per cycle, then go to DONE.
REQ-010 DONE SHALL last one cycle, with done=hiWrite=loWrite=1, then return to IDLE.
REQ-011 Latency: done SHALL be high in the cycle after the 33rd rising edge following the accepting edge; busy SHALL be high from the accepting edge until DONE/DZERO is exited.
REQ-012 MULT SHALL operate on magnitudes with a shift-add over a 64-bit accumulator, then negate the 64-bit result if opA[31]^opB[31].
REQ-013 DIV SHALL use a restoring algorithm on magnitudes. The quotient SHALL be negated if the operand signs differ. The remainder SHALL take the sign of the dividend.
REQ-014 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wrap, no exception).
REQ-015 |0x80000000| SHALL be treated as the unsigned value 2^31, using 33-bit internal magnitudes.
REQ-016 hi and lo SHALL update only on the edge entering DONE and SHALL hold between operations.
REQ-017 done, div0, hiWrite and loWrite SHALL never be high in the same cycle as each other, except that hiWrite and loWrite equal done.

Reset
REQ-018 reset low SHALL immediately force IDLE, counter=0, busy=done=div0=hiWrite=loWrite=0 and hi=lo=0, regardless of clock.
REQ-019 A reset during MULT or DIV SHALL abort the operation with no write pulse.
REQ-020 After reset rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-021 MULT 7 * 0xFFFFFFFD (-3) -> done one cycle after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
REQ-022 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; hiWrite=loWrite=1 for one cycle.
REQ-023 DIV 5/0 -> div0 pulse in the cycle after acceptance, busy for one cycle, hi/lo keep their prior values, no done.
REQ-024 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-025 multStart pulse at iteration 10 of a running DIV 100/7 -> ignored; result lo=14, hi=2. multStart and divStart together -> MULT executed.
REQ-026 reset low at iteration 20 of MULT -> all outputs 0 asynchronously. After release, MULT 3*4 -> lo=12, hi=0.
